prim_lzc_shared_arbiter: RTL and testbench

PRIM_LZC_SHARED_ARBITER -- requirements
Module: prim_lzc_shared_arbiter

---
 rtl/prim_lzc_shared_arbiter.sv | 112 +++++++++++
 tb/tb_prim_lzc_shared_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_lzc_shared_arbiter.sv
// Two-port front end sharing one 32-bit leading-zero counter behind a
// single-entry result register with round-robin or fixed-priority grant.

module prim_lzc_shared_arbiter #(
  parameter int unsigned ARB_MODE = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  input  logic [31:0] i_req0_data,
  output logic        o_req0_ready,
  output logic        o_rsp0_valid,
  input  logic        i_rsp0_ready,
  output logic [4:0]  o_rsp0_nlz,
  output logic        o_rsp0_all_zero,
  input  logic        i_req1_valid,
  input  logic [31:0] i_req1_data,
  output logic        o_req1_ready,
  output logic        o_rsp1_valid,
  input  logic        i_rsp1_ready,
  output logic [4:0]  o_rsp1_nlz,
  output logic        o_rsp1_all_zero
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NLZ_W  = 5;

  logic              r_valid;
  logic              r_owner;
  logic [NLZ_W-1:0]  r_nlz;
  logic              r_all_zero;
  logic              r_rr;

  logic              w_drain;
  logic              w_free;
  logic              w_grant;
  logic              w_accept;
  logic [DATA_W-1:0] w_lzc_data;
  logic [NLZ_W-1:0]  w_lzc_nlz;
  logic              w_lzc_zero;

  // Output stage frees up when empty or when its owner consumes this cycle.
  assign w_drain = r_valid & (r_owner ? i_rsp1_ready : i_rsp0_ready);
  assign w_free  = i_rst_n & (~r_valid | w_drain);

  always_comb begin
    w_grant = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      w_grant = (ARB_MODE == 1) ? 1'b0 : r_rr;
    end else if (i_req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign o_req0_ready = w_free & i_req0_valid & ~w_grant;
  assign o_req1_ready = w_free & i_req1_valid & w_grant;
  assign w_accept     = o_req0_ready | o_req1_ready;
  assign w_lzc_data   = w_grant ? i_req1_data : i_req0_data;

  prim_lzc32 u_lzc (
    .i_data     (w_lzc_data),
    .o_nlz      (w_lzc_nlz),
    .o_all_zero (w_lzc_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid    <= 1'b0;
      r_owner    <= 1'b0;
      r_nlz      <= '0;
      r_all_zero <= 1'b0;
      r_rr       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_valid    <= 1'b1;
        r_owner    <= w_grant;
        r_nlz      <= w_lzc_zero ? NLZ_W'(0) : w_lzc_nlz;
        r_all_zero <= w_lzc_zero;
        r_rr       <= ~w_grant;
      end else if (w_drain) begin
        r_valid    <= 1'b0;
      end
    end
  end

  assign o_rsp0_valid    = r_valid & ~r_owner;
  assign o_rsp1_valid    = r_valid & r_owner;
  assign o_rsp0_nlz      = o_rsp0_valid ? r_nlz : '0;
  assign o_rsp1_nlz      = o_rsp1_valid ? r_nlz : '0;
  assign o_rsp0_all_zero = o_rsp0_valid & r_all_zero;
  assign o_rsp1_all_zero = o_rsp1_valid & r_all_zero;

endmodule

// 32-bit leading-zero counter; nlz is 0 when the operand is zero.
module prim_lzc32 (
  input  logic [31:0] i_data,
  output logic [4:0]  o_nlz,
  output logic        o_all_zero
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    o_nlz = '0;
    for (int i = 0; i < 32; i++) begin
      if (i_data[i]) o_nlz = 5'(31 - i);
    end
  end

  assign o_all_zero = ~|i_data;

endmodule

// File: tb/tb_prim_lzc_shared_arbiter.sv
// Scoreboard bench for prim_lzc_shared_arbiter: round-robin instance under
// full checking, plus a fixed-priority instance sharing the same stimulus.

module tb_prim_lzc_shared_arbiter;

  typedef struct {
    bit         port;
    logic [4:0] nlz;
    logic       az;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        v0, v1, rr0, rr1;
  logic [31:0] d0, d1;
  logic        rdy0, rdy1, rv0, rv1, az0, az1;
  logic [4:0]  nlz0, nlz1;
  logic        b_rdy0, b_rdy1, b_rv0, b_rv1, b_az0, b_az1;
  logic [4:0]  b_nlz0, b_nlz1;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  prim_lzc_shared_arbiter #(.ARB_MODE(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .i_req0_data(d0), .o_req0_ready(rdy0),
    .o_rsp0_valid(rv0), .i_rsp0_ready(rr0), .o_rsp0_nlz(nlz0), .o_rsp0_all_zero(az0),
    .i_req1_valid(v1), .i_req1_data(d1), .o_req1_ready(rdy1),
    .o_rsp1_valid(rv1), .i_rsp1_ready(rr1), .o_rsp1_nlz(nlz1), .o_rsp1_all_zero(az1)
  );

  prim_lzc_shared_arbiter #(.ARB_MODE(1)) dut_fp (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .i_req0_data(d0), .o_req0_ready(b_rdy0),
    .o_rsp0_valid(b_rv0), .i_rsp0_ready(rr0), .o_rsp0_nlz(b_nlz0), .o_rsp0_all_zero(b_az0),
    .i_req1_valid(v1), .i_req1_data(d1), .o_req1_ready(b_rdy1),
    .o_rsp1_valid(b_rv1), .i_rsp1_ready(rr1), .o_rsp1_nlz(b_nlz1), .o_rsp1_all_zero(b_az1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input bit port, input logic [31:0] d);
    exp_t e;
    int   k = 0;
    while (k < 32 && d[31-k] == 1'b0) k++;
    e.port = port;
    e.az   = (k == 32);
    e.nlz  = e.az ? 5'd0 : 5'(k);
    return e;
  endfunction

  function automatic logic [31:0] rand_data();
    int          s = $urandom_range(0, 32);
    logic [31:0] r = $urandom | 32'h8000_0000;
    return (s == 32) ? 32'h0 : (r >> s);
  endfunction

  // Scoreboard monitor: pops on drain, pushes on request handshake.
  always @(negedge clk) begin
    exp_t e;
    bit   p;
    if (!rst_n) begin
      sb.delete();
      total++;
      if ({rv0, rv1, rdy0, rdy1, az0, az1} !== 6'b0 || nlz0 !== 5'd0 || nlz1 !== 5'd0) begin
        bad++;
        $display("FAIL reset_outputs got rv=%b%b rdy=%b%b az=%b%b nlz=%0d/%0d want all 0",
                 rv0, rv1, rdy0, rdy1, az0, az1, nlz0, nlz1);
      end
    end else begin
      total++;
      if (rdy0 && rdy1) begin
        bad++;
        $display("FAIL ready_onehot got rdy0=1 rdy1=1 want at most one");
      end
      if (!rv0 && !rv1) begin
        total++;
        if (sb.size() != 0) begin
          bad++;
          $display("FAIL rsp_missing got no rsp_valid want port%0d result", sb[0].port);
        end
      end else begin
        p = rv1;
        total++;
        if (rv0 && rv1) begin
          bad++;
          $display("FAIL rsp_both got rv0=1 rv1=1 want one");
        end else if (sb.size() == 0) begin
          bad++;
          $display("FAIL rsp_spurious got rsp on port%0d want none", p);
        end else begin
          e = sb[0];
          if (e.port !== p || (p ? nlz1 : nlz0) !== e.nlz || (p ? az1 : az0) !== e.az) begin
            bad++;
            $display("FAIL sb_result got port=%0d nlz=%0d az=%b want port=%0d nlz=%0d az=%b",
                     p, p ? nlz1 : nlz0, p ? az1 : az0, e.port, e.nlz, e.az);
          end
          if (p ? rr1 : rr0) void'(sb.pop_front());
        end
        total++;
        if ((p ? nlz0 : nlz1) !== 5'd0 || (p ? az0 : az1) !== 1'b0) begin
          bad++;
          $display("FAIL idle_port_zero got nlz=%0d az=%b want 0/0",
                   p ? nlz0 : nlz1, p ? az0 : az1);
        end
      end
      if (v0 && rdy0) sb.push_back(model(1'b0, d0));
      if (v1 && rdy1) sb.push_back(model(1'b1, d1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 32'h1; d1 = 32'h2; rr0 = 1'b1; rr1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
        bad++;
        $display("FAIL reset_ready got %b%b want 00", rdy0, rdy1);
      end
    end
    step();
  endtask

  task automatic test_single();
    rst_n = 1'b1; v0 = 1'b1; v1 = 1'b0; d0 = 32'h0001_0000; rr0 = 1'b1;
    @(negedge clk);
    total++;
    if (rdy0 !== 1'b1) begin bad++; $display("FAIL single_ready0 got %b want 1", rdy0); end
    step();
    v0 = 1'b0;
    @(negedge clk);
    total++;
    if (rv0 !== 1'b1 || nlz0 !== 5'd15 || az0 !== 1'b0) begin
      bad++;
      $display("FAIL single_rsp got v=%b nlz=%0d az=%b want 1/15/0", rv0, nlz0, az0);
    end
    step();
  endtask

  task automatic test_rr_alternate();
    pulse_reset();
    rst_n = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 32'h8000_0000; d1 = 32'h0000_0001;
    rr0 = 1'b1; rr1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (rdy0 !== (k % 2 == 0) || rdy1 !== (k % 2 == 1)) begin
        bad++;
        $display("FAIL rr_grant cyc=%0d got rdy=%b%b want port%0d", k, rdy0, rdy1, k % 2);
      end
      if (k > 0) begin
        total++;
        if (((k - 1) % 2 == 0) ? (rv0 !== 1'b1 || nlz0 !== 5'd0)
                               : (rv1 !== 1'b1 || nlz1 !== 5'd31)) begin
          bad++;
          $display("FAIL rr_rsp cyc=%0d got rv=%b%b nlz=%0d/%0d want port%0d",
                   k, rv0, rv1, nlz0, nlz1, (k - 1) % 2);
        end
      end
      step();
    end
    v0 = 1'b0; v1 = 1'b0;
    step();
  endtask

  task automatic test_fixed_prio();
    pulse_reset();
    rst_n = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 32'h8000_0000; d1 = 32'h0000_0001;
    rr0 = 1'b1; rr1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (b_rdy0 !== 1'b1 || b_rdy1 !== 1'b0) begin
        bad++;
        $display("FAIL fp_grant cyc=%0d got rdy=%b%b want 10", k, b_rdy0, b_rdy1);
      end
      if (k > 0) begin
        total++;
        if (b_rv0 !== 1'b1 || b_rv1 !== 1'b0 || b_nlz0 !== 5'd0) begin
          bad++;
          $display("FAIL fp_rsp cyc=%0d got rv=%b%b nlz=%0d want 10/0", k, b_rv0, b_rv1, b_nlz0);
        end
      end
      step();
    end
    v0 = 1'b0; v1 = 1'b0;
    step();
  endtask

  task automatic test_zero();
    v0 = 1'b0; v1 = 1'b1; d1 = 32'h0; rr1 = 1'b1;
    @(negedge clk);
    total++;
    if (rdy1 !== 1'b1) begin bad++; $display("FAIL zero_ready1 got %b want 1", rdy1); end
    step();
    v1 = 1'b0;
    @(negedge clk);
    total++;
    if (rv1 !== 1'b1 || nlz1 !== 5'd0 || az1 !== 1'b1) begin
      bad++;
      $display("FAIL zero_rsp got v=%b nlz=%0d az=%b want 1/0/1", rv1, nlz1, az1);
    end
    step();
  endtask

  task automatic test_backpressure();
    v0 = 1'b1; v1 = 1'b0; d0 = 32'h00F0_0000; rr0 = 1'b0; rr1 = 1'b1;
    @(negedge clk);
    total++;
    if (rdy0 !== 1'b1) begin bad++; $display("FAIL bp_accept got %b want 1", rdy0); end
    step();
    v0 = 1'b0; v1 = 1'b1; d1 = 32'h0000_0100;
    for (int k = 0; k < 3; k++) begin
      rr1 = k[0];
      @(negedge clk);
      total++;
      if (rv0 !== 1'b1 || nlz0 !== 5'd8 || rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got rv0=%b nlz0=%0d rdy=%b%b want 1/8/00",
                 k, rv0, nlz0, rdy0, rdy1);
      end
      step();
    end
    rr0 = 1'b1; rr1 = 1'b1;
    @(negedge clk);
    total++;
    if (rdy1 !== 1'b1 || rv0 !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got rdy1=%b rv0=%b want 1/1", rdy1, rv0);
    end
    step();
    v1 = 1'b0;
    @(negedge clk);
    total++;
    if (rv1 !== 1'b1 || nlz1 !== 5'd23 || rv0 !== 1'b0) begin
      bad++;
      $display("FAIL bp_next got rv1=%b nlz1=%0d rv0=%b want 1/23/0", rv1, nlz1, rv0);
    end
    step();
  endtask

  task automatic test_reset_mid();
    v0 = 1'b1; v1 = 1'b0; d0 = 32'h1; rr0 = 1'b0; rr1 = 1'b1;
    @(negedge clk);
    total++;
    if (rdy0 !== 1'b1) begin bad++; $display("FAIL rst_mid_accept got %b want 1", rdy0); end
    step();
    v0 = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (rv0 !== 1'b0 || rv1 !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_drop got rv=%b%b want 00", rv0, rv1);
    end
    step();
    step();
    rst_n = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 32'h0000_0010; d1 = 32'h1; rr0 = 1'b1;
    @(negedge clk);
    total++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_first got rdy=%b%b want 10", rdy0, rdy1);
    end
    step();
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    total++;
    if (rv0 !== 1'b1 || nlz0 !== 5'd27) begin
      bad++;
      $display("FAIL rst_mid_rsp got rv0=%b nlz0=%0d want 1/27", rv0, nlz0);
    end
    step();
  endtask

  task automatic test_back_to_back();
    bit hs0, hs1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      hs0 = v0 && rdy0;
      hs1 = v1 && rdy1;
      step();
      if (!v0 || hs0) begin v0 = ($urandom_range(0, 3) != 0); d0 = rand_data(); end
      if (!v1 || hs1) begin v1 = ($urandom_range(0, 3) != 0); d1 = rand_data(); end
      rr0 = ($urandom_range(0, 3) != 0);
      rr1 = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    step();
    v0 = 1'b0; v1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
    for (int c = 0; c < 3; c++) step();
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_alternate();
    test_fixed_prio();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
